// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the iterative CORDIC engine:
//     - ATAN_DEG_Q24 : atan(2^-i) in degrees, 24 fractional bits, truncated
//     - ATAN_FRAC    : fractional bits of ATAN_DEG_Q24
//     - CORDIC_GAIN_Q16 : CORDIC gain K (~1.6468) in Q16, for downstream compensation
//     - cordic_state_e  : engine FSM states
package cordic_pkg;

  localparam int ATAN_FRAC = 24;

  localparam logic [31:0] ATAN_DEG_Q24 [0:15] = '{
    32'd754974720, 32'd445687601, 32'd235489088, 32'd119537938,
    32'd60000934,  32'd30029716,  32'd15018522,  32'd7509719,
    32'd3754917,   32'd1877465,   32'd938733,    32'd469366,
    32'd234683,    32'd117341,    32'd58670,     32'd29335
  };

  localparam int CORDIC_GAIN_Q16 = 107922;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } cordic_state_e;

endpackage

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut
//   Combinational arctan table for one micro-rotation stage, rescaled from the
//   Q24 master table to the engine's angle format.
//   Ports:
//     idx  in  4        stage index 0..15
//     atan out ANGLE_W  atan(2^-idx) in degrees, ANGLE_FRAC fractional bits
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int ANGLE_W    = 16,
  parameter int ANGLE_FRAC = 7
) (
  input  logic [3:0]                idx,
  output logic signed [ANGLE_W-1:0] atan
);

  localparam int SHIFT = ATAN_FRAC - ANGLE_FRAC;

  logic [31:0] full;

  // Entries are positive and already truncated, so a plain right shift keeps
  // the floor identical to truncating the real value directly.
  always_comb begin
    full = ATAN_DEG_Q24[idx];
    atan = ANGLE_W'(full >> SHIFT);
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine
//   Iterative CORDIC: one micro-rotation per clock on a single add/shift
//   datapath. Rotation mode rotates (x,y) by z degrees (fixed point); gain K is
//   not compensated. Optional vector mode with `define CORDIC_VECTOR_EN.
//   Ports:
//     clk, resetn            clock (rising), async active-low reset
//     in_valid / in_ready    operand handshake (in_ready = engine idle)
//     x_in, y_in  [DATA_W]   signed operand
//     z_in        [ANGLE_W]  signed angle, [-180,+180] deg
//     mode                   0=rotate 1=vector (CORDIC_VECTOR_EN only)
//     out_valid / out_ready  result handshake, result held until taken
//     x_out, y_out [DATA_W+2] signed result
//     z_out       [ANGLE_W]  residual (rotate) / accumulated (vector) angle
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ANGLE_W    = 16,
  parameter int ANGLE_FRAC = 7,
  parameter int STAGES     = 12
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  x_in,
  input  logic signed [DATA_W-1:0]  y_in,
  input  logic signed [ANGLE_W-1:0] z_in,
`ifdef CORDIC_VECTOR_EN
  input  logic                      mode,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W+1:0]  x_out,
  output logic signed [DATA_W+1:0]  y_out,
  output logic signed [ANGLE_W-1:0] z_out
);

  localparam int W = DATA_W + 2;
  localparam logic signed [ANGLE_W-1:0] Z90  = ANGLE_W'(90 <<< ANGLE_FRAC);
  localparam logic signed [ANGLE_W-1:0] Z180 = ANGLE_W'(180 <<< ANGLE_FRAC);
  localparam logic [3:0] LAST = 4'(STAGES - 1);

  function automatic logic signed [W-1:0] sext_in(input logic signed [DATA_W-1:0] v);
    return {{2{v[DATA_W-1]}}, v};
  endfunction

  cordic_state_e state_q, state_d;
  logic [3:0]                cnt_q;
  logic signed [W-1:0]       x_q, y_q;
  logic signed [ANGLE_W-1:0] z_q;
`ifdef CORDIC_VECTOR_EN
  logic                      mode_q;
`endif

  logic signed [W-1:0]       x_sh, y_sh, x_nx, y_nx;
  logic signed [ANGLE_W-1:0] z_nx, z_pre, atan_i;
  logic                      d_pos, pre_flip;

  cordic_atan_lut #(
    .ANGLE_W    (ANGLE_W),
    .ANGLE_FRAC (ANGLE_FRAC)
  ) u_lut (
    .idx  (cnt_q),
    .atan (atan_i)
  );

  // Quadrant pre-rotation so the remaining angle lies within CORDIC convergence.
  always_comb begin
    pre_flip = 1'b0;
    z_pre    = z_q;
    if (z_q > Z90) begin
      pre_flip = 1'b1;
      z_pre    = z_q - Z180;
    end else if (z_q < -Z90) begin
      pre_flip = 1'b1;
      z_pre    = z_q + Z180;
    end
`ifdef CORDIC_VECTOR_EN
    if (mode_q) begin
      pre_flip = x_q[W-1];
      z_pre    = !x_q[W-1] ? z_q : (y_q[W-1] ? z_q - Z180 : z_q + Z180);
    end
`endif
  end

  // Micro-rotation datapath shared by all stages.
  always_comb begin
`ifdef CORDIC_VECTOR_EN
    d_pos = mode_q ? y_q[W-1] : ~z_q[ANGLE_W-1];
`else
    d_pos = ~z_q[ANGLE_W-1];
`endif
    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
    x_nx = d_pos ? x_q - y_sh   : x_q + y_sh;
    y_nx = d_pos ? y_q + x_sh   : y_q - x_sh;
    z_nx = d_pos ? z_q - atan_i : z_q + atan_i;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = PRE;
      end
      PRE:  state_d = ITER;
      ITER: if (cnt_q == LAST) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
`ifdef CORDIC_VECTOR_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          x_q    <= sext_in(x_in);
          y_q    <= sext_in(y_in);
          z_q    <= z_in;
          cnt_q  <= '0;
`ifdef CORDIC_VECTOR_EN
          mode_q <= mode;
`endif
        end
        PRE: begin
          if (pre_flip) begin
            x_q <= -x_q;
            y_q <= -y_q;
          end
          z_q   <= z_pre;
          cnt_q <= '0;
        end
        ITER: begin
          x_q   <= x_nx;
          y_q   <= y_nx;
          z_q   <= z_nx;
          cnt_q <= (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign x_out = x_q;
  assign y_out = y_q;
  assign z_out = z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb_cordic_iter_engine
//   Directed bench for cordic_iter_engine at default parameters (STAGES=12,
//   ANGLE_FRAC=7). Vector-mode vectors run only with `define CORDIC_VECTOR_EN.
//   Also checks the arctan table directly through cordic_atan_lut.
module tb_cordic_iter_engine;

  logic clk = 1'b0;
  logic resetn;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [15:0] x_in, y_in, z_in;
  logic signed [17:0] x_out, y_out;
  logic signed [15:0] z_out;
`ifdef CORDIC_VECTOR_EN
  logic mode;
`endif

  logic [3:0]         lut_idx;
  logic signed [15:0] lut_atan;

  int total = 0;
  int bad   = 0;

  logic signed [17:0] rx, ry;
  logic signed [15:0] rz;
  int lat;

  always #5 clk = ~clk;

  cordic_iter_engine #(
    .DATA_W(16), .ANGLE_W(16), .ANGLE_FRAC(7), .STAGES(12)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
`ifdef CORDIC_VECTOR_EN
    .mode(mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  cordic_atan_lut #(.ANGLE_W(16), .ANGLE_FRAC(7)) u_lut_chk (
    .idx(lut_idx), .atan(lut_atan)
  );

  task automatic check_val(input string tag, input longint got, input longint want,
                           input longint tol);
    longint diff;
    total++;
    diff = got - want;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, got, want, tol);
    end
  endtask

  // Accept edge is edge 0; out_valid set by edge 13 is seen downstream at edge 14.
  task automatic run_op(input int xi, input int yi, input int zi, input logic md);
    @(posedge clk); #1;
    x_in = 16'(xi); y_in = 16'(yi); z_in = 16'(zi);
`ifdef CORDIC_VECTOR_EN
    mode = md;
`else
    if (md) $display("note: vector request ignored in rotate-only build");
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", lat, 13, 0);
    rx = x_out; ry = y_out; rz = z_out;
  endtask

  int exp_lut [0:9] = '{5760, 3400, 1796, 912, 457, 229, 114, 57, 28, 14};

  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; y_in = '0; z_in = '0; lut_idx = '0;
`ifdef CORDIC_VECTOR_EN
    mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 1, 0);
    check_val("rst_out_valid", out_valid, 0, 0);
    check_val("rst_x_out", x_out, 0, 0);
    check_val("rst_y_out", y_out, 0, 0);
    check_val("rst_z_out", z_out, 0, 0);
    resetn = 1'b1;

    // Rotation vectors
    run_op(10000, 0, 0, 1'b0);
    check_val("rot0_x", rx, 16468, 16);
    check_val("rot0_y", ry, 0, 16);
    check_val("rot0_z", rz, 0, 8);

    run_op(10000, 0, 11520, 1'b0);
    check_val("rot90_x", rx, 0, 16);
    check_val("rot90_y", ry, 16468, 16);
    check_val("rot90_z", rz, 0, 8);

    run_op(10000, 0, -17280, 1'b0);
    check_val("rotm135_x", rx, -11645, 16);
    check_val("rotm135_y", ry, -11645, 16);
    check_val("rotm135_z", rz, 0, 8);

    run_op(0, 10000, -11520, 1'b0);
    check_val("rotm90_x", rx, 16468, 16);
    check_val("rotm90_y", ry, 0, 16);

    // Backpressure: result held while out_ready is low
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(10000, 0, 5760, 1'b0);
    check_val("bp_x", rx, 11645, 16);
    check_val("bp_y", ry, 11645, 16);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("bp_hold_valid", out_valid, 1, 0);
      check_val("bp_hold_ready", in_ready, 0, 0);
      check_val("bp_hold_x", x_out, rx, 0);
      check_val("bp_hold_y", y_out, ry, 0);
      check_val("bp_hold_z", z_out, rz, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_valid", out_valid, 0, 0);
    check_val("bp_release_ready", in_ready, 1, 0);

    // Reset in the middle of ITER
    @(posedge clk); #1;
    x_in = 16'sd10000; y_in = '0; z_in = 16'sd2000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check_val("mid_busy", in_ready, 0, 0);
    resetn = 1'b0;
    #1;
    check_val("abort_out_valid", out_valid, 0, 0);
    check_val("abort_in_ready", in_ready, 1, 0);
    check_val("abort_x_out", x_out, 0, 0);
    check_val("abort_z_out", z_out, 0, 0);
    @(posedge clk); #1;
    check_val("abort_still_idle", in_ready, 1, 0);
    resetn = 1'b1;
    run_op(10000, 0, 0, 1'b0);
    check_val("post_rst_x", rx, 16468, 16);
    check_val("post_rst_y", ry, 0, 16);
    check_val("post_rst_z", rz, 0, 8);

`ifdef CORDIC_VECTOR_EN
    run_op(3000, 4000, 0, 1'b1);
    check_val("vec_x", rx, 8234, 16);
    check_val("vec_y", ry, 0, 16);
    check_val("vec_z", rz, 6800, 8);
    run_op(-3000, 4000, 0, 1'b1);
    check_val("vec_q2_x", rx, 8234, 16);
    check_val("vec_q2_y", ry, 0, 16);
    check_val("vec_q2_z", rz, 16240, 8);
`endif

    // Arctan table at ANGLE_FRAC=7
    for (int i = 0; i < 10; i++) begin
      lut_idx = 4'(i);
      #1;
      check_val($sformatf("lut%0d", i), lut_atan, exp_lut[i], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
